// File: rtl/encoder_8x3_seq.sv
// Sequential 8-to-3 encoder: captures a multi-hot vector and emits one code per set bit over a valid/ready handshake.
// Define ENC_MSB_FIRST_EN to emit the highest-index set bit first; lowest-index first otherwise.
module encoder_8x3_seq (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       En,
   input  logic       load,
   input  logic [7:0] D,
   input  logic       out_ready,
   output logic       A,
   output logic       B,
   output logic       C,
   output logic       out_valid,
   output logic       busy,
   output logic       done
);

   typedef enum logic {IDLE, EMIT} state_t;

   state_t     state;
   state_t     state_next;
   logic [7:0] pending;
   logic [7:0] pending_next;
   logic       done_next;
   logic [2:0] sel_idx;

   // Scan order: the last matching bit visited by the loop wins the selection
   always_comb begin
      sel_idx = 3'd0;
`ifdef ENC_MSB_FIRST_EN
      for (int i = 0; i < 8; i++)
         if (pending[i]) sel_idx = 3'(i);
`else
      for (int i = 7; i >= 0; i--)
         if (pending[i]) sel_idx = 3'(i);
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         pending <= 8'd0;
         done    <= 1'b0;
      end else begin
         state   <= state_next;
         pending <= pending_next;
         done    <= done_next;
      end
   end

   // With En low every register keeps its value, including a pending done pulse
   always_comb begin
      state_next   = state;
      pending_next = pending;
      done_next    = done;
      if (En) begin
         done_next = 1'b0;
         case (state)
            IDLE: begin
               if (load) begin
                  if (D != 8'd0) begin
                     pending_next = D;
                     state_next   = EMIT;
                  end else begin
                     done_next = 1'b1;
                  end
               end
            end
            EMIT: begin
               if (out_ready) begin
                  pending_next = pending & ~(8'b1 << sel_idx);
                  if (pending_next == 8'd0) begin
                     state_next = IDLE;
                     done_next  = 1'b1;
                  end
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

   always_comb begin
      out_valid   = (state == EMIT);
      busy        = (state == EMIT);
      {A, B, C}   = (state == EMIT) ? sel_idx : 3'd0;
   end

endmodule

// File: doc/encoder_8x3_seq.md
ENCODER_8X3_SEQ -- requirements
Module: encoder_8x3_seq

Interface
REQ-001 No parameters; vector width fixed at 8, code width fixed at 3.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 En  input  1  enable; when 0 the block freezes (no state change, outputs hold).
REQ-005 load  input  1  request to capture D; honoured only when En=1 and busy=0.
REQ-006 D  input  8  one-hot or multi-hot line vector to encode; bit i maps to code i.
REQ-007 out_ready  input  1  consumer accepts current code when high with out_valid.
REQ-008 A  output  1  code bit 2 (MSB).
REQ-009 B  output  1  code bit 1.
REQ-010 C  output  1  code bit 0 (LSB).
REQ-011 out_valid  output  1  {A,B,C} holds a valid code.
REQ-012 busy  output  1  a captured vector is still being drained.
REQ-013 done  output  1  one-cycle pulse after the last code of a vector is accepted.

Function
REQ-014 States: IDLE, EMIT; internal 8-bit pending register holds not-yet-emitted bits.
REQ-015 IDLE, En=1, load=1, D!=0: pending<=D, go EMIT; out_valid=1 in the next cycle (latency 1).
REQ-016 IDLE, En=1, load=1, D=0: stay IDLE, pending stays 0, done pulses for one cycle the next cycle, no code emitted.
REQ-017 EMIT: out_valid=1, busy=1, {A,B,C}=index of the selected set bit of pending (order per REQ-030).
REQ-018 Handshake: transfer occurs on a rising edge with En=1, out_valid=1, out_ready=1; the selected bit is cleared from pending.
REQ-019 Transfer of the last set bit: next state IDLE, out_valid=0, busy=0, done=1 for exactly that next cycle.
REQ-020 While out_valid=1 and no transfer occurs, {A,B,C} and out_valid SHALL remain stable.
REQ-021 load in EMIT is ignored; D is not sampled; no effect on pending.
REQ-022 En=0 in any state: state, pending, and all outputs hold; a transfer does not occur even if out_ready=1; done, if high, stays high until the next En=1 cycle completes.
REQ-023 Outputs derive only from registers; no combinational path from D, load, out_ready, or En to any output.
REQ-024 In IDLE, {A,B,C}=000 and out_valid=0.
REQ-025 Back-to-back: load accepted in the same cycle done is high (state IDLE) SHALL be honoured.

Reset
REQ-026 rst_n=0 asynchronously forces state IDLE, pending=0, A=B=C=0, out_valid=0, busy=0, done=0.
REQ-027 Reset mid-EMIT discards remaining pending bits; no done pulse is generated.
REQ-028 Deassertion of rst_n takes effect at the next rising clk edge; first load accepted on that edge.

Configuration
REQ-029 Macro ENC_MSB_FIRST_EN selects scan order.
REQ-030 Without ENC_MSB_FIRST_EN: lowest-index set bit emitted first; with it defined: highest-index set bit emitted first; all other behaviour identical.

Verification
REQ-031 Load D=8'b0000_0100, out_ready=1 -> next cycle out_valid=1, ABC=010; following cycle out_valid=0, done=1 for one cycle.
REQ-032 Load D=8'b1000_0011, out_ready=1 -> codes 000,001,111 on consecutive cycles (ENC_MSB_FIRST_EN: 111,001,000), then done=1.
REQ-033 Load D=8'b0001_0000, out_ready=0 for 5 cycles -> ABC=100 and out_valid=1 held stable all 5 cycles; accepted when out_ready=1.
REQ-034 Load D=8'h00 -> no out_valid, done=1 one cycle later, busy stays 0.
REQ-035 Load D=8'hFF, drop En for 3 cycles after second code with out_ready=1 -> no codes consumed during En=0; remaining 6 codes follow in order.
REQ-036 Load D=8'hF0, assert rst_n=0 after first transfer -> all outputs 0 immediately, no done; new load D=8'h01 after release yields ABC=000.
